score_text_renderer: RTL
========================

# score_text_renderer

Pixel stage directly downstream of the SCORE label sprite decoder. It takes the per-letter hit flags and glyph row address for the current pixel, drives the synchronous font ROM, and selects the glyph bit for the current column. It registers the result into a pixel-on strobe and colour for the colour mapper. It also optionally blinks the label for a fixed number of frames when a score event is signalled.

## Interface
- TEXT_RGB, 24'hFFFFFF: colour driven when a glyph bit is set.
- X_ORIGIN, 10'd527: left edge of the first letter; all glyphs are 8 px wide from here.
- FLASH_FRAMES, 120: length of a flash burst in frames (1..255).
- TOGGLE_FRAMES, 8: frames per visible/blank half-period (1..255).
- Clk  in  1  pixel clock.
- Reset_n  in  1  asynchronous, active-low reset.
- DrawX  in  10  current pixel column.
- DrawY  in  10  current pixel row (carried for debug; not used in selection).
- is_S_Score, is_C_Score, is_O_Score, is_R_Score, is_E_Score  in  1 each  letter hit flags (at most one high).
- addr_score  in  11  font ROM row address for the current pixel.
- frame_start  in  1  one-cycle pulse at start of each frame.
- score_flash  in  1  one-cycle pulse that starts or restarts a flash burst.
- font_addr  out  11  address to the font ROM, which has 1-cycle read latency.
- font_data  in  8  ROM row, returned one cycle after font_addr; bit 7 is the leftmost pixel.
- score_pixel_on  out  1  label pixel is lit.
- score_rgb  out  24  TEXT_RGB when score_pixel_on, else 24'h000000.
- letter_idx  out  3  S=0, C=1, O=2, R=3, E=4, none=7; aligned with score_pixel_on.

## Operation
- font_addr = addr_score combinationally; no gating.
- Stage 1 (registered):
  - hit1 = OR of the five flags.
  - col1 = (DrawX - X_ORIGIN)[2:0], computed as a 10-bit subtraction truncated to 3 bits.
  - idx1 = encoded letter.
- Stage 2 (registered):
  - score_pixel_on = hit1 & font_data[7 - col1] & visible.
  - score_rgb follows score_pixel_on.
  - letter_idx = idx1 when hit1, else 7.
- visible is 1 whenever no burst is active.
- Flash burst, when compiled in:
  - Registers: frames_left (8 bit), phase_cnt (8 bit), blank (1 bit).
  - score_flash loads frames_left = FLASH_FRAMES, phase_cnt = TOGGLE_FRAMES and blank = 1, so the burst starts blanked.
  - On each frame_start while frames_left != 0:
    - frames_left decrements.
    - phase_cnt decrements. When phase_cnt reaches 1 it reloads TOGGLE_FRAMES and blank toggles.
  - When frames_left reaches 0, blank clears.
  - visible = ~blank.
- score_flash and frame_start in the same cycle: the load wins and no decrement occurs that cycle.
- score_flash during a burst restarts the burst from full length.
- frame_start with frames_left == 0 changes nothing.

## Timing
- Latency from DrawX/flags to score_pixel_on/score_rgb/letter_idx is exactly 2 Clk cycles. Downstream delays sync/blank by 2 cycles to match.
- Throughput is one pixel per cycle with no stalls.
- Flash state changes take effect on the stage-2 register in the cycle after the triggering pulse. Visibility changes only at frame boundaries.
- Reset values, applied asynchronously on Reset_n low:
  - score_pixel_on = 0, score_rgb = 24'h000000, letter_idx = 7.
  - hit1 = 0, col1 = 0, idx1 = 7.
  - frames_left = 0, phase_cnt = 0, blank = 0.
- Reset asserted mid-burst aborts the burst, and the label is visible after reset release.
- A flag pulse in the first cycle after reset release is rendered normally.

## Configuration
- SCORE_FLASH_EN defined: the flash burst logic is built as described.
- SCORE_FLASH_EN undefined:
  - No flash registers are built.
  - visible is tied to 1.
  - score_flash and frame_start are ignored; the ports remain present.
  - Pixel datapath and latency are unchanged.

## Test plan
- Reset: hold Reset_n=0 with flags active and font_data=8'hFF -> score_pixel_on=0, score_rgb=0, letter_idx=7 throughout.
- S glyph render:
  - DrawX=527..534 with is_S_Score=1, addr_score=1328.
  - ROM model returns 8'b1000_0001 one cycle after font_addr=1328.
  - Expected: score_pixel_on = 1,0,0,0,0,0,0,1 two cycles later, with letter_idx=0.
- Boundary: DrawX=534 (S) then 535 (C, col=0), font_data bit7=1 -> score_pixel_on=1 and letter_idx=1 on the C pixel. No flag (DrawX=567) -> score_pixel_on=0, letter_idx=7.
- Flash burst (macro defined, FLASH_FRAMES=4, TOGGLE_FRAMES=2), with a lit pixel each frame:
  - score_flash pulse -> blank for the first 2 frames, visible for frames 3-4, visible thereafter.
- Simultaneous score_flash and frame_start: frames_left=4 after the cycle, not 3.
- Retrigger mid-burst: frames_left is reloaded to 4.
- Reset mid-burst: Reset_n low while blank=1 -> pixel lit immediately after release.
- Macro undefined: score_flash pulse -> output identical to the no-flash run.

Source files
------------

// File: rtl/score_text_renderer.sv
// score_text_renderer: two-stage SCORE label pixel path driving the font ROM, with optional blink burst.
// Define SCORE_FLASH_EN to build the flash-burst logic; otherwise the label is always visible.
module score_text_renderer #(
  parameter logic [23:0] TEXT_RGB      = 24'hFFFFFF,
  parameter logic [9:0]  X_ORIGIN      = 10'd527,
  parameter int          FLASH_FRAMES  = 120,
  parameter int          TOGGLE_FRAMES = 8
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        is_S_Score,
  input  logic        is_C_Score,
  input  logic        is_O_Score,
  input  logic        is_R_Score,
  input  logic        is_E_Score,
  input  logic [10:0] addr_score,
  input  logic        frame_start,
  input  logic        score_flash,
  output logic [10:0] font_addr,
  input  logic [7:0]  font_data,
  output logic        score_pixel_on,
  output logic [23:0] score_rgb,
  output logic [2:0]  letter_idx
);
  logic       w_hit1;
  logic [2:0] w_col1;
  logic [2:0] w_idx1;
  logic       w_visible;
  logic       r_hit1;
  logic [2:0] r_col1;
  logic [2:0] r_idx1;
  logic       r_on;
  logic [2:0] r_idx;

  assign font_addr = addr_score;
  assign w_hit1    = is_S_Score | is_C_Score | is_O_Score | is_R_Score | is_E_Score;
  assign w_col1    = 3'(DrawX - X_ORIGIN);
  assign w_idx1    = is_S_Score ? 3'd0 : is_C_Score ? 3'd1 : is_O_Score ? 3'd2 :
                     is_R_Score ? 3'd3 : is_E_Score ? 3'd4 : 3'd7;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_hit1 <= 1'b0;
      r_col1 <= 3'd0;
      r_idx1 <= 3'd7;
      r_on   <= 1'b0;
      r_idx  <= 3'd7;
    end else begin
      r_hit1 <= w_hit1;
      r_col1 <= w_col1;
      r_idx1 <= w_idx1;
      // font_data arrives one cycle after font_addr, aligned with the stage-1 registers
      r_on   <= r_hit1 & font_data[3'd7 - r_col1] & w_visible;
      r_idx  <= r_hit1 ? r_idx1 : 3'd7;
    end
  end

  assign score_pixel_on = r_on;
  assign score_rgb      = r_on ? TEXT_RGB : 24'h000000;
  assign letter_idx     = r_idx;

`ifdef SCORE_FLASH_EN
  localparam logic [7:0] LP_FLASH  = 8'(FLASH_FRAMES);
  localparam logic [7:0] LP_TOGGLE = 8'(TOGGLE_FRAMES);
  logic       w_unused;
  logic [7:0] r_frames_left;
  logic [7:0] r_phase_cnt;
  logic       r_blank;

  assign w_unused = ^DrawY;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_frames_left <= 8'd0;
      r_phase_cnt   <= 8'd0;
      r_blank       <= 1'b0;
    end else if (score_flash) begin
      r_frames_left <= LP_FLASH;
      r_phase_cnt   <= LP_TOGGLE;
      r_blank       <= 1'b1;
    end else if (frame_start && r_frames_left != 8'd0) begin
      r_frames_left <= r_frames_left - 8'd1;
      r_phase_cnt   <= (r_phase_cnt == 8'd1) ? LP_TOGGLE : r_phase_cnt - 8'd1;
      // the final frame of a burst always ends visible, overriding any pending toggle
      r_blank       <= (r_frames_left == 8'd1) ? 1'b0 : (r_phase_cnt == 8'd1) ? ~r_blank : r_blank;
    end
  end

  assign w_visible = ~r_blank;
`else
  logic w_unused;
  assign w_unused  = ^{DrawY, frame_start, score_flash, 8'(FLASH_FRAMES), 8'(TOGGLE_FRAMES)};
  assign w_visible = 1'b1;
`endif
endmodule
